// File: rtl/toi2s_pkg.sv
// Shared defaults and small helpers for the toi2s datapath.
// toi2s_tt_top instantiates the I2S transmitter with these values.
package toi2s_pkg;

  localparam int unsigned TOI2S_SAMPLE_W = 24;
  localparam int unsigned TOI2S_SLOT_W   = 32;
  localparam int unsigned TOI2S_BCK_DIV  = 4;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int unsigned toi2s_cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/toi2s_i2s_timing.sv
// I2S bit-clock divider and frame position counter; drives registered BCK/WS
// and strobes for the BCK falling edge and the frame boundary.
module toi2s_i2s_timing
  import toi2s_pkg::*;
#(
  parameter int unsigned SLOT_W  = TOI2S_SLOT_W,
  parameter int unsigned BCK_DIV = TOI2S_BCK_DIV,
  localparam int unsigned BIT_W  = toi2s_cnt_w(2 * SLOT_W)
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             ena,
  output logic [BIT_W-1:0] bit_cnt_nxt,
  output logic             bck_fall,
  output logic             frame_start,
  output logic             bck,
  output logic             ws
);

  localparam int unsigned DIV_W = toi2s_cnt_w(BCK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_W);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bck_q, bck_d;
  logic             ws_q, ws_d;

  always_comb begin
    bck_fall    = ena && (div_cnt_q == DIV_LAST);
    frame_start = bck_fall && (bit_cnt_q == BIT_LAST);
    div_cnt_d   = '0;
    bit_cnt_d   = '0;
    if (ena) begin
      div_cnt_d = bck_fall ? '0 : div_cnt_q + DIV_W'(1);
      bit_cnt_d = bit_cnt_q;
      if (bck_fall) begin
        bit_cnt_d = frame_start ? '0 : bit_cnt_q + BIT_W'(1);
      end
    end
    // Outputs are derived from next-state counters so they line up with the
    // counter state they describe, without a combinational output path.
    bck_d       = (div_cnt_d >= DIV_HALF);
    ws_d        = (bit_cnt_d >= BIT_SLOT);
    bit_cnt_nxt = bit_cnt_d;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bck_q     <= 1'b0;
      ws_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bck_q     <= bck_d;
      ws_q      <= ws_d;
    end
  end

  assign bck = bck_q;
  assign ws  = ws_q;

endmodule

// File: rtl/toi2s_i2s_tx.sv
// Philips I2S master transmitter: one-deep stereo holding buffer feeding a
// per-frame register that is serialized MSB first one BCK after each WS edge.
module toi2s_i2s_tx
  import toi2s_pkg::*;
#(
  parameter int unsigned SAMPLE_W = TOI2S_SAMPLE_W,
  parameter int unsigned SLOT_W   = TOI2S_SLOT_W,
  parameter int unsigned BCK_DIV  = TOI2S_BCK_DIV
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                ena,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                i2s_bck,
  output logic                i2s_ws,
  output logic                i2s_d0,
  output logic                underrun
);

  localparam int unsigned BIT_W = toi2s_cnt_w(2 * SLOT_W);

  logic [BIT_W-1:0]    bit_cnt_nxt;
  logic                bck_fall;
  logic                frame_start;

  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
  logic                hold_full_q, hold_full_d;
  logic [SAMPLE_W-1:0] frame_l_q, frame_l_d;
  logic [SAMPLE_W-1:0] frame_r_q, frame_r_d;
  logic                d0_q, d0_d;
  logic                underrun_q, underrun_d;

  logic                accept;
  logic                d0_sel;
  logic [SAMPLE_W-1:0] shifted;
  int unsigned         b;

  toi2s_i2s_timing #(
    .SLOT_W  (SLOT_W),
    .BCK_DIV (BCK_DIV)
  ) u_timing (
    .clk         (clk),
    .resetb      (resetb),
    .ena         (ena),
    .bit_cnt_nxt (bit_cnt_nxt),
    .bck_fall    (bck_fall),
    .frame_start (frame_start),
    .bck         (i2s_bck),
    .ws          (i2s_ws)
  );

  assign sample_ready = ena & ~hold_full_q;
  assign accept       = sample_valid & sample_ready;

  // Holding buffer and frame register. On a boundary the frame takes the
  // buffer contents as they were before any same-cycle accept (no bypass).
  always_comb begin
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    frame_l_d   = frame_l_q;
    frame_r_d   = frame_r_q;
    underrun_d  = 1'b0;
    if (!ena) begin
      hold_l_d    = '0;
      hold_r_d    = '0;
      hold_full_d = 1'b0;
      frame_l_d   = '0;
      frame_r_d   = '0;
    end else begin
      if (frame_start) begin
        frame_l_d   = hold_full_q ? hold_l_q : '0;
        frame_r_d   = hold_full_q ? hold_r_q : '0;
        underrun_d  = ~hold_full_q;
        hold_full_d = 1'b0;
      end
      if (accept) begin
        hold_l_d    = sample_l;
        hold_r_d    = sample_r;
        hold_full_d = 1'b1;
      end
    end
  end

  // Serial data select for the slot position the counters are about to enter.
  always_comb begin
    b       = 32'(bit_cnt_nxt);
    d0_sel  = 1'b0;
    shifted = '0;
    if (b >= 1 && b <= SAMPLE_W) begin
      shifted = frame_l_d >> (SAMPLE_W - b);
      d0_sel  = shifted[0];
    end else if (b >= SLOT_W + 1 && b <= SLOT_W + SAMPLE_W) begin
      shifted = frame_r_d >> (SAMPLE_W - (b - SLOT_W));
      d0_sel  = shifted[0];
    end
    d0_d = (bck_fall || !ena) ? d0_sel : d0_q;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      frame_l_q   <= '0;
      frame_r_q   <= '0;
      d0_q        <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      frame_l_q   <= frame_l_d;
      frame_r_q   <= frame_r_d;
      d0_q        <= d0_d;
      underrun_q  <= underrun_d;
    end
  end

  assign i2s_d0   = d0_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_toi2s_i2s_tx.sv
// Self-checking bench for toi2s_i2s_tx against a frame-position reference model.
module tb_toi2s_i2s_tx;
  import toi2s_pkg::*;

  localparam int unsigned W     = TOI2S_SAMPLE_W;
  localparam int unsigned S     = TOI2S_SLOT_W;
  localparam int unsigned DIV   = TOI2S_BCK_DIV;
  localparam int unsigned FRAME = DIV * 2 * S;

  logic         clk;
  logic         resetb;
  logic         ena;
  logic [W-1:0] sample_l;
  logic [W-1:0] sample_r;
  logic         sample_valid;
  logic         sample_ready;
  logic         i2s_bck;
  logic         i2s_ws;
  logic         i2s_d0;
  logic         underrun;

  int vectors;
  int miscompares;

  // Reference model: position in frame plus buffer/frame contents.
  int unsigned  mt;
  logic         m_hold_full;
  logic [W-1:0] m_hold_l, m_hold_r;
  logic [W-1:0] m_frame_l, m_frame_r;
  logic         m_under;

  toi2s_i2s_tx #(
    .SAMPLE_W (W),
    .SLOT_W   (S),
    .BCK_DIV  (DIV)
  ) dut (
    .clk          (clk),
    .resetb       (resetb),
    .ena          (ena),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_bck      (i2s_bck),
    .i2s_ws       (i2s_ws),
    .i2s_d0       (i2s_d0),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mt          = 0;
    m_hold_full = 1'b0;
    m_hold_l    = '0;
    m_hold_r    = '0;
    m_frame_l   = '0;
    m_frame_r   = '0;
    m_under     = 1'b0;
  endtask

  function automatic logic exp_d0(input int unsigned t);
    int unsigned bb;
    bb = (t / DIV) % (2 * S);
    if (bb >= 1 && bb <= W) return m_frame_l[W - bb];
    if (bb >= S + 1 && bb <= S + W) return m_frame_r[W - (bb - S)];
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0d: observed %b expected %b", tag, mt, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("bck",      i2s_bck,      (mt % DIV) >= DIV / 2);
    chk("ws",       i2s_ws,       ((mt / DIV) % (2 * S)) >= S);
    chk("d0",       i2s_d0,       exp_d0(mt));
    chk("underrun", underrun,     m_under);
    chk("ready",    sample_ready, ena && !m_hold_full);
  endtask

  // One clk: check at negedge, then advance the model across the posedge.
  task automatic step(output logic acc);
    @(negedge clk);
    check_outputs();
    acc = resetb && ena && sample_valid && !m_hold_full;
    @(posedge clk);
    if (!resetb || !ena) begin
      model_reset();
    end else begin
      m_under = 1'b0;
      if (mt == FRAME - 1) begin
        m_under     = !m_hold_full;
        m_frame_l   = m_hold_full ? m_hold_l : '0;
        m_frame_r   = m_hold_full ? m_hold_r : '0;
        m_hold_full = 1'b0;
      end
      if (acc) begin
        m_hold_l    = sample_l;
        m_hold_r    = sample_r;
        m_hold_full = 1'b1;
      end
      mt = (mt + 1) % FRAME;
    end
    #1;
  endtask

  task automatic send_one_and_wait(input int unsigned extra);
    logic acc;
    logic got;
    got = 1'b0;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      sample_valid = 1'b1;
      sample_l     = W'($urandom);
      sample_r     = W'($urandom);
      step(acc);
      if (acc) got = 1'b1;
    end
    sample_valid = 1'b0;
    for (int i = 0; i < int'(extra); i++) step(acc);
  endtask

  initial begin
    logic        acc;
    logic        done;
    logic [W-1:0] base;

    vectors      = 0;
    miscompares  = 0;
    resetb       = 1'b0;
    ena          = 1'b1;
    sample_valid = 1'b0;
    sample_l     = '0;
    sample_r     = '0;
    model_reset();

    repeat (3) step(acc);
    resetb = 1'b1;

    // Single pair during frame 0, then one frame with and one without data.
    for (int i = 0; i < 3 * int'(FRAME); i++) begin
      sample_valid = (i == 10);
      sample_l     = (i == 10) ? W'(24'hA5A5A5) : '0;
      sample_r     = (i == 10) ? W'(24'h5A5A5A) : '0;
      step(acc);
    end

    // Idle: underrun every frame, data stays zero.
    sample_valid = 1'b0;
    for (int i = 0; i < 2 * int'(FRAME); i++) step(acc);

    // Back-pressure with continuous valid and incrementing data.
    base = W'($urandom);
    for (int i = 0; i < 5 * int'(FRAME); i++) begin
      sample_valid = 1'b1;
      sample_l     = base;
      sample_r     = ~base;
      step(acc);
      if (acc) base = base + W'(1);
    end

    // Accept exactly on a boundary cycle with an empty buffer.
    sample_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 4 * int'(FRAME); i++) begin
      sample_valid = !done && (mt == FRAME - 1) && !m_hold_full;
      sample_l     = W'($urandom);
      sample_r     = W'($urandom);
      if (sample_valid) done = 1'b1;
      step(acc);
    end
    chk("boundary_accept_seen", done, 1'b1);

    // Random traffic.
    for (int i = 0; i < 4 * int'(FRAME); i++) begin
      sample_valid = ($urandom % 6) == 0;
      sample_l     = W'($urandom);
      sample_r     = W'($urandom);
      step(acc);
    end
    sample_valid = 1'b0;

    // Asynchronous reset mid-frame with a sample held.
    send_one_and_wait(40);
    #2 resetb = 1'b0;
    #1;
    model_reset();
    chk("rst_bck",      i2s_bck,      1'b0);
    chk("rst_ws",       i2s_ws,       1'b0);
    chk("rst_d0",       i2s_d0,       1'b0);
    chk("rst_underrun", underrun,     1'b0);
    chk("rst_ready",    sample_ready, 1'b1);
    repeat (4) step(acc);
    resetb = 1'b1;
    for (int i = 0; i < 2 * int'(FRAME) + 20; i++) step(acc);

    // ena drop mid-frame with a sample held; held sample is lost.
    send_one_and_wait(300);
    ena = 1'b0;
    #1;
    chk("ena_low_ready", sample_ready, 1'b0);
    repeat (6) step(acc);
    ena = 1'b1;
    for (int i = 0; i < 2 * int'(FRAME) + 20; i++) step(acc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/toi2s_i2s_tx.md
# toi2s_i2s_tx

I2S transmitter stage of the toi2s datapath. It takes parallel stereo PCM samples from the decoder/volume stage through a one-deep valid/ready holding buffer. It serializes them as standard Philips I2S (bit clock, word select, data) driving the amplifier pins amp_i2s_bck, amp_i2s_ws and amp_i2s_d0 inside toi2s_tt_top. It acts as I2S bus master and derives the bit clock from the system clock.

## Interface
Parameters:
- SAMPLE_W, 24: PCM sample width; legal range 1..SLOT_W-1.
- SLOT_W, 32: BCK cycles per channel slot; frame length = 2*SLOT_W BCK cycles.
- BCK_DIV, 4: clk cycles per BCK period; even, ≥2.

Ports:
- clk  in  1  system clock
- resetb  in  1  reset; asynchronous, active-low
- ena  in  1  block enable; low = synchronous clear of all state except resetb-only flops (none)
- sample_l  in  SAMPLE_W  left sample, two's complement
- sample_r  in  SAMPLE_W  right sample, two's complement
- sample_valid  in  1  sample pair valid
- sample_ready  out  1  holding buffer empty and ena high
- i2s_bck  out  1  bit clock
- i2s_ws  out  1  word select (0 = left, 1 = right)
- i2s_d0  out  1  serial data, MSB first
- underrun  out  1  one-clk pulse: frame started with holding buffer empty

## Operation
- Counters:
  - div_cnt runs 0..BCK_DIV-1.
  - bit_cnt runs 0..2*SLOT_W-1 and advances when div_cnt wraps to 0 (BCK falling edge).
- Output values as functions of the current counters:
  - i2s_bck = (div_cnt ≥ BCK_DIV/2).
  - i2s_ws = (bit_cnt ≥ SLOT_W).
  - i2s_d0 = left bit SAMPLE_W-b when 1 ≤ b ≤ SAMPLE_W; right bit SAMPLE_W-(b-SLOT_W) when SLOT_W+1 ≤ b ≤ SLOT_W+SAMPLE_W; 0 otherwise.
  - As a result, the MSB follows each WS transition by one BCK cycle, and unused slot bits are zero.
- Holding buffer (hold_l, hold_r, hold_full):
  - sample_ready = ena & ~hold_full.
  - When sample_valid & sample_ready, the sample pair is captured and hold_full is set.
- Frame boundary = cycle with div_cnt==BCK_DIV-1 and bit_cnt==2*SLOT_W-1. On the next edge:
  - Counters go to 0.
  - The frame register (frame_l, frame_r) loads hold_l/hold_r if hold_full, and hold_full clears.
  - Otherwise the frame register loads zeros and underrun pulses for one clk.
- There is no bypass. A sample accepted on the boundary cycle goes into the holding buffer, and the frame loads zeros (underrun) if the buffer was empty.
- When ena is low, every clk forces the following, and operation restarts from the reset state when ena rises:
  - Counters = 0.
  - hold_full = 0.
  - Frame register = 0.
  - All outputs = 0.

## Timing
- Reset (resetb low, async): div_cnt=0, bit_cnt=0, hold_full=0, frame register=0, i2s_bck=0, i2s_ws=0, i2s_d0=0, underrun=0. sample_ready follows ena.
- i2s_bck, i2s_ws, i2s_d0 and underrun are flops. They are computed from next-state counters so the values hold in the same cycle as the counter state; no combinational output paths.
- i2s_ws and i2s_d0 change only on cycles where i2s_bck falls. The amplifier samples on the BCK rising edge.
- Frame 0 after reset or ena rise always plays zeros. A sample accepted during frame N plays in frame N+1.
- Back-pressure: after an accept, sample_ready stays low until the cycle after the next frame boundary.
- Defaults: BCK = clk/4, frame = 256 clk.
- Reset mid-frame: all state clears immediately and the held sample is discarded.

## Structure
- Package toi2s_pkg holds the defaults TOI2S_SAMPLE_W=24, TOI2S_SLOT_W=32 and TOI2S_BCK_DIV=4. toi2s_tt_top instantiates the block with these values.
- One sub-module, toi2s_i2s_timing, owns div_cnt and bit_cnt. It outputs bit_cnt, a bck_fall strobe, a frame_start strobe and the registered bck/ws.
- The top level owns the holding buffer, the frame register, d0 selection and underrun.

## Test plan
- Reset values: assert resetb=0 mid-frame → all outputs 0 within the same cycle. Release with ena=1 → sample_ready=1 and the BCK period is 4 clk.
- Single pair: send L=0xA5A5A5, R=0x5A5A5A during frame 0.
  - Frame 1: MSB of L appears one BCK after WS falls, then 24 bits 0xA5A5A5, then 7 zeros.
  - WS rises at BCK 32; R=0x5A5A5A is MSB-first from BCK 33.
- Underrun: no samples are sent → underrun pulses exactly once per 256 clk at each frame start and d0 stays 0. With one sample sent, underrun is absent for the frame that plays it.
- Back-pressure: hold sample_valid high continuously with incrementing data.
  - Exactly one accept per frame.
  - sample_ready re-rises one clk after each boundary.
  - The serial data sequence matches the accepted sequence with no loss or duplication.
- Boundary accept: sample_valid rises on the boundary cycle with the buffer empty → underrun pulses, the frame plays zeros, and the sample plays in the following frame.
- ena drop: deassert ena mid-frame with a sample held → outputs and sample_ready go 0. Re-enable → the first frame plays zeros and the held sample is lost.
